hash_b64_encoder: RTL and testbench
===================================

// Module: hash_b64_encoder
// PURPOSE
//  Converts the packed 326-bit result from output_rst into the 60-char modular-crypt string
//  "$2b$cc$<22 salt chars><31 ctext chars>", emitted one ASCII byte per handshake.
//  Sits directly downstream of output_rst and feeds the chip's byte-wide host interface.
//  Uses the bcrypt radix-64 alphabet "./A-Za-z0-9" (codes 0..63).
// PARAMETERS
//  VER_CHAR   8'h62 ("b")  minor-version letter emitted as byte 2
// PORTS
//  clk        in   1    single clock; all state updates on posedge clk
//  rst        in   1    asynchronous, active-high reset
//  hash       in   326  {cost[325:320], salt[319:192], ctext[191:0]}, MSB = first byte on wire
//  hash_valid in   1    hash is valid; sampled only while hash_ready=1
//  hash_ready out  1    encoder idle, can capture a hash
//  out_data   out  8    ASCII character
//  out_valid  out  1    out_data valid
//  out_ready  in   1    downstream accepts out_data this cycle
//  out_last   out  1    qualifies the 60th character (index 59)
//  busy       out  1    encoding in progress (== ~hash_ready)
// BEHAVIOUR
//  - Clocking/reset: one clock (clk); rst is asynchronous, active-high. While rst: state=IDLE,
//    char index=0, shift regs=0, hash_ready=1, out_valid=0, out_last=0, out_data=0, busy=0.
//  - Capture: hash_valid & hash_ready at posedge -> register cost, salt, ctext[191:8];
//    ctext[7:0] is discarded. State -> PREFIX, idx=0.
//  - Latency: out_valid rises 1 cycle after capture. hash_valid while busy is ignored.
//  - Char handshake: a char is consumed when out_valid & out_ready. Otherwise out_data,
//    out_valid and out_last hold stable (no bubbles, no change while stalled).
//  - FSM (idx = 6-bit char counter 0..59, increments on each handshake):
//      IDLE   -> PREFIX on capture
//      PREFIX idx0-3: "$", "2", VER_CHAR, "$"; -> COST after idx3
//      COST   idx4-5: tens, units of cost as ASCII ("0".."6", "0".."9");
//             idx6: "$"; -> SALT
//      SALT   idx7-28: 22 chars from the salt shift reg. 128 bits are zero-padded to 132;
//             char k = bits [127-6k -: 6]. The last char is 2 data bits + 4 zeros. -> CTEXT
//      CTEXT  idx29-59: 31 chars from ctext[191:8]. 184 bits are zero-padded to 186.
//             The last char is 4 data bits + 2 zeros. out_last=1 at idx59.
//      On the idx59 handshake -> IDLE. hash_ready=1 the next cycle, so back-to-back
//      hashes cost 1 idle cycle.
//  - Arithmetic: cost is 0..63, with no range check. tens = cost/10 via a compare chain
//    (>=60, >=50, ... >=10); units = cost - 10*tens (6-bit). Shift regs shift left by 6
//    on each handshake in SALT/CTEXT, with zero fill.
//  - Reset mid-stream: the partial string is abandoned and nothing more is emitted.
//    The next capture restarts at "$".
//  - out_ready held high: exactly 60 consecutive valid cycles per hash.
// STRUCTURE
//  - bcrypt_pkg: typedef enum {IDLE, PREFIX, COST, SALT, CTEXT} enc_state_t;
//    HASH_W=326, N_CHARS=60, SALT_CHARS=22, CT_CHARS=31, CT_BITS=184;
//    ASCII constants for "$" and "2".
//  - Sub-module b64_char_map (combinational, 6-bit code -> 8-bit ASCII):
//    0-1 -> "./", 2-27 -> "A"-"Z", 28-53 -> "a"-"z", 54-63 -> "0"-"9".
//  - Top level holds the FSM, idx counter, salt/ctext shift regs and output register.
// TESTING
//  1 cost=10, salt=0, ctext=0, out_ready=1 -> "$2b$10$" + 53x"."; out_last only on
//    char 60; 60 consecutive valid cycles.
//  2 cost=31, salt=all 1s, ctext=all 1s -> "$2b$31$" + 21x"9" + "u" + 30x"9" + "6".
//  3 cost=4, salt=128'h8000..0 -> cost chars "04"; salt chars "e" then 21x".";
//    ctext[7:0]=8'hFF alone -> all 31 ctext chars ".".
//  4 Random out_ready (~50% duty) -> out_data/out_last stable while stalled;
//    the char sequence is identical to test 1.
//  5 hash_valid pulsed at char 20 with a different hash -> ignored, hash_ready=0;
//    the string finishes unchanged. A new hash offered the cycle after idx59
//    is captured 1 cycle later.
//  6 rst asserted at char 35 -> out_valid=0 and hash_ready=1 immediately; the next
//    capture emits from "$".

Source files
------------

// File: rtl/bcrypt_pkg.sv
// ============================================================================
// Module   : bcrypt_pkg
// Brief    : Shared types and constants for the bcrypt hash string encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcrypt_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREFIX = 3'd1,
        COST   = 3'd2,
        SALT   = 3'd3,
        CTEXT  = 3'd4
    } enc_state_t;

    localparam int HASH_W     = 326;
    localparam int N_CHARS    = 60;
    localparam int SALT_CHARS = 22;
    localparam int CT_CHARS   = 31;
    localparam int CT_BITS    = 184;
    localparam int SALT_BITS  = 128;

    localparam logic [7:0] c_ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] c_ASCII_TWO    = 8'h32;
    localparam logic [7:0] c_ASCII_ZERO   = 8'h30;

    // Index of the first character of each field, and of the final character.
    localparam logic [5:0] c_IDX_COST_FIRST = 6'd4;
    localparam logic [5:0] c_IDX_COST_SEP   = 6'd6;
    localparam logic [5:0] c_IDX_SALT_FIRST = 6'd7;
    localparam logic [5:0] c_IDX_CT_FIRST   = 6'd29;
    localparam logic [5:0] c_IDX_LAST       = 6'd59;

    // Tens digit of a 6-bit cost via a compare chain (no divider).
    function automatic logic [2:0] cost_tens(input logic [5:0] cost);
        logic [2:0] tens;
        if      (cost >= 6'd60) tens = 3'd6;
        else if (cost >= 6'd50) tens = 3'd5;
        else if (cost >= 6'd40) tens = 3'd4;
        else if (cost >= 6'd30) tens = 3'd3;
        else if (cost >= 6'd20) tens = 3'd2;
        else if (cost >= 6'd10) tens = 3'd1;
        else                    tens = 3'd0;
        return tens;
    endfunction

endpackage

`default_nettype wire

// File: rtl/b64_char_map.sv
// ============================================================================
// Module   : b64_char_map
// Brief    : bcrypt radix-64 code to ASCII ("./A-Za-z0-9"), combinational.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module b64_char_map (
    input  logic [5:0] code,
    output logic [7:0] ascii
);

    logic [7:0] w_code8;

    assign w_code8 = {2'b00, code};

    always_comb begin
        ascii = 8'h00;
        if (code < 6'd2)
            ascii = w_code8 + 8'h2E;        // '.' '/'
        else if (code < 6'd28)
            ascii = w_code8 + 8'h3F;        // 'A'..'Z'
        else if (code < 6'd54)
            ascii = w_code8 + 8'h45;        // 'a'..'z'
        else
            ascii = w_code8 - 8'h06;        // '0'..'9'
    end

endmodule

`default_nettype wire

// File: rtl/hash_b64_encoder.sv
// ============================================================================
// Module   : hash_b64_encoder
// Brief    : Packs cost/salt/ctext into the 60-char "$2b$cc$..." string, one
//            byte per out_valid/out_ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hash_b64_encoder
    import bcrypt_pkg::*;
#(
    parameter logic [7:0] VER_CHAR = 8'h62
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HASH_W-1:0] hash,
    input  logic              hash_valid,
    output logic              hash_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    enc_state_t               r_state, w_state_nxt;
    logic [5:0]               r_idx, w_idx_nxt;
    logic [5:0]               r_cost, w_cost_nxt;
    logic [SALT_BITS-1:0]     r_salt, w_salt_nxt;
    logic [CT_BITS-1:0]       r_ct, w_ct_nxt;
    logic [7:0]               r_out_data, w_data_nxt;
    logic                     r_out_valid, w_valid_nxt;
    logic                     r_out_last, w_last_nxt;

    logic                     w_fire;
    logic [5:0]               w_idx_inc;
    logic [SALT_BITS-1:0]     w_salt_adv;
    logic [CT_BITS-1:0]       w_ct_adv;
    logic [5:0]               w_code;
    logic [7:0]               w_b64_char;
    logic [2:0]               w_tens;
    logic [5:0]               w_units;
    logic [7:0]               w_next_char;
    enc_state_t               w_next_field;
    logic                     w_unused_ct_lsb;

    // ctext[7:0] never reaches the string.
    assign w_unused_ct_lsb = ^hash[7:0];

    assign w_fire    = r_out_valid & out_ready;
    assign w_idx_inc = r_idx + 6'd1;

    // The output register always holds the presented char; on a handshake the
    // next char is built from the shift regs as they will look after the shift.
    assign w_salt_adv = (r_state == SALT)  ? {r_salt[SALT_BITS-7:0], 6'b0} : r_salt;
    assign w_ct_adv   = (r_state == CTEXT) ? {r_ct[CT_BITS-7:0], 6'b0}     : r_ct;
    assign w_code     = (w_idx_inc < c_IDX_CT_FIRST) ? w_salt_adv[SALT_BITS-1 -: 6]
                                                     : w_ct_adv[CT_BITS-1 -: 6];

    assign w_tens  = cost_tens(r_cost);
    assign w_units = r_cost - ({3'b000, w_tens} * 6'd10);

    b64_char_map u_char_map (
        .code  (w_code),
        .ascii (w_b64_char)
    );

    always_comb begin
        w_next_char  = w_b64_char;
        w_next_field = CTEXT;
        if (w_idx_inc < c_IDX_COST_FIRST) begin
            w_next_field = PREFIX;
            case (w_idx_inc[1:0])
                2'd1:    w_next_char = c_ASCII_TWO;
                2'd2:    w_next_char = VER_CHAR;
                default: w_next_char = c_ASCII_DOLLAR;
            endcase
        end else if (w_idx_inc < c_IDX_SALT_FIRST) begin
            w_next_field = COST;
            if (w_idx_inc == c_IDX_COST_FIRST)
                w_next_char = c_ASCII_ZERO + {5'b00000, w_tens};
            else if (w_idx_inc == c_IDX_COST_SEP)
                w_next_char = c_ASCII_DOLLAR;
            else
                w_next_char = c_ASCII_ZERO + {2'b00, w_units};
        end else if (w_idx_inc < c_IDX_CT_FIRST) begin
            w_next_field = SALT;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cost_nxt  = r_cost;
        w_salt_nxt  = r_salt;
        w_ct_nxt    = r_ct;
        w_data_nxt  = r_out_data;
        w_valid_nxt = r_out_valid;
        w_last_nxt  = r_out_last;
        case (r_state)
            IDLE: begin
                if (hash_valid) begin
                    w_state_nxt = PREFIX;
                    w_idx_nxt   = 6'd0;
                    w_cost_nxt  = hash[325:320];
                    w_salt_nxt  = hash[319:192];
                    w_ct_nxt    = hash[191:8];
                    w_data_nxt  = c_ASCII_DOLLAR;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = 1'b0;
                end
            end
            PREFIX, COST, SALT, CTEXT: begin
                if (w_fire) begin
                    w_salt_nxt = w_salt_adv;
                    w_ct_nxt   = w_ct_adv;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = 6'd0;
                        w_data_nxt  = 8'h00;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = w_next_field;
                        w_idx_nxt   = w_idx_inc;
                        w_data_nxt  = w_next_char;
                        w_last_nxt  = (w_idx_inc == c_IDX_LAST);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= 6'd0;
            r_cost      <= 6'd0;
            r_salt      <= '0;
            r_ct        <= '0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cost      <= w_cost_nxt;
            r_salt      <= w_salt_nxt;
            r_ct        <= w_ct_nxt;
            r_out_data  <= w_data_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
        end
    end

    assign hash_ready = (r_state == IDLE);
    assign busy       = ~hash_ready;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_hash_b64_encoder.sv
// ============================================================================
// Module   : tb_hash_b64_encoder
// Brief    : Scoreboard bench for hash_b64_encoder with a bit-string model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hash_b64_encoder;

    logic         clk = 1'b0;
    logic         rst;
    logic [325:0] hash;
    logic         hash_valid;
    logic         hash_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int pop_count = 0;
    logic [8:0] sb[$];

    logic       stall_prev = 1'b0;
    logic [7:0] stall_data;
    logic       stall_last;

    always #5 clk = ~clk;

    hash_b64_encoder #(.VER_CHAR(8'h62)) dut (
        .clk        (clk),
        .rst        (rst),
        .hash       (hash),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] alpha(input logic [5:0] code);
        string s;
        s = "./ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789";
        return s[code];
    endfunction

    // Reference string built by slicing zero-padded bit strings.
    task automatic push_hash(input logic [5:0] cost, input logic [127:0] salt,
                             input logic [191:0] ct);
        logic [131:0] sbits;
        logic [185:0] cbits;
        logic [7:0]   ch;
        int           k;
        sbits = {salt, 4'b0};
        cbits = {ct[191:8], 2'b0};
        for (int i = 0; i < 60; i++) begin
            case (i)
                0, 3, 6: ch = "$";
                1:       ch = "2";
                2:       ch = "b";
                4:       ch = 8'(int'("0") + int'(cost) / 10);
                5:       ch = 8'(int'("0") + int'(cost) % 10);
                default: begin
                    if (i < 29) begin
                        k  = i - 7;
                        ch = alpha(sbits[131 - 6*k -: 6]);
                    end else begin
                        k  = i - 29;
                        ch = alpha(cbits[185 - 6*k -: 6]);
                    end
                end
            endcase
            sb.push_back({(i == 59), ch});
        end
    endtask

    // Scoreboard monitor plus stall-stability check.
    always @(negedge clk) begin
        logic [8:0] e;
        if (stall_prev && out_valid) begin
            check("stall_data", {24'd0, out_data}, {24'd0, stall_data});
            check("stall_last", {31'd0, out_last}, {31'd0, stall_last});
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        stall_last = out_last;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_char", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check($sformatf("char%0d", pop_count), {24'd0, out_data}, {24'd0, e[7:0]});
                check($sformatf("last%0d", pop_count), {31'd0, out_last}, {31'd0, e[8]});
            end
            pop_count++;
        end
    end

    task automatic send_hash(input logic [5:0] cost, input logic [127:0] salt,
                             input logic [191:0] ct);
        int t;
        t = 0;
        while (!hash_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("ready_before_send", {31'd0, hash_ready}, 32'd1);
        hash       = {cost, salt, ct};
        hash_valid = 1'b1;
        push_hash(cost, salt, ct);
        @(posedge clk); #1;
        hash_valid = 1'b0;
        check("busy_after_capture", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_drain(input bit rand_ready);
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 2000) begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            t++;
        end
        out_ready = 1'b1;
        check("drain_timeout", {31'd0, (t >= 2000)}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);
    endtask

    task automatic wait_pops(input int target);
        int t;
        t = 0;
        while (pop_count < target && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("pop_wait_timeout", {31'd0, (t >= 500)}, 32'd0);
    endtask

    initial begin
        int cnt;
        int t;
        rst        = 1'b1;
        hash       = '0;
        hash_valid = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hash_ready", {31'd0, hash_ready}, 32'd1);
        check("rst_out_valid",  {31'd0, out_valid},  32'd0);
        check("rst_out_last",   {31'd0, out_last},   32'd0);
        check("rst_out_data",   {24'd0, out_data},   32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: cost 10, zeros; count consecutive valid cycles
        send_hash(6'd10, 128'd0, 192'd0);
        cnt = 0;
        @(negedge clk);
        while (out_valid && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("t1_valid_cycles", cnt, 32'd60);
        wait_drain(1'b0);

        // 2: all ones
        send_hash(6'd31, {128{1'b1}}, {192{1'b1}});
        wait_drain(1'b0);

        // 3: single salt MSB, only discarded ctext bits set
        send_hash(6'd4, {1'b1, 127'd0}, {184'd0, 8'hFF});
        wait_drain(1'b0);

        // 4: random back-pressure
        send_hash(6'd10, 128'd0, 192'd0);
        wait_drain(1'b1);

        // 5: hash offered mid-stream is ignored; next one right after idx59
        send_hash(6'd17, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                  192'hDEAD_BEEF_0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
        wait_pops(pop_count + 20);
        hash       = {6'd63, {128{1'b1}}, {192{1'b1}}};
        hash_valid = 1'b1;
        @(negedge clk);
        check("t5_ready_busy", {31'd0, hash_ready}, 32'd0);
        @(posedge clk); #1;
        hash_valid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!(out_valid && out_last) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t5_last_timeout", {31'd0, (t >= 200)}, 32'd0);
        @(posedge clk); #1;
        hash       = {6'd63, {128{1'b1}}, 192'h1234_5678};
        hash_valid = 1'b1;
        push_hash(6'd63, {128{1'b1}}, 192'h1234_5678);
        @(negedge clk);
        check("t5_ready_after_last", {31'd0, hash_ready}, 32'd1);
        check("t5_idle_gap",         {31'd0, out_valid},  32'd0);
        @(posedge clk); #1;
        hash_valid = 1'b0;
        @(negedge clk);
        check("t5_valid_next", {31'd0, out_valid}, 32'd1);
        wait_drain(1'b0);

        // 6: reset mid-stream
        send_hash(6'd12, 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0, 192'h77);
        wait_pops(pop_count + 35);
        rst = 1'b1;
        #1;
        check("t6_valid_rst", {31'd0, out_valid},  32'd0);
        check("t6_ready_rst", {31'd0, hash_ready}, 32'd1);
        check("t6_last_rst",  {31'd0, out_last},   32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_hash(6'd5, 128'hFFFF_0000_FFFF_0000_1111_2222_3333_4444, 192'hABCDEF);
        wait_drain(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
